// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Mode encoding and the high-phase length used by TOGGLE channels.
package clk_div_pkg;

   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_PULSE  = 1'b1;

   // Cycles the TOGGLE output stays high in one period of length d.
   function automatic logic [31:0] half_ceil(input logic [31:0] d);
      return (d + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow configuration and
// registered clk_out/tick outputs. Configuration changes land only on a period boundary.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             enable,
   input  logic             wr,
   input  logic [DIV_W-1:0] div_val,
   input  logic             mode_val,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic             mode_q;
   logic [DIV_W-1:0] shadow_div;
   logic             shadow_mode;

   logic             running;
   logic [DIV_W-1:0] last_cnt;
   logic             at_last;
   logic             boundary;
   logic             apply;
   logic [31:0]      high_len;
   logic             high_phase;

   always_comb begin
      running    = enable && (div_q != '0);
      // D-1 only evaluated for a non-zero divisor, so it never underflows.
      last_cnt   = running ? (div_q - {{(DIV_W-1){1'b0}}, 1'b1}) : '0;
      at_last    = running && (cnt == last_cnt);
      boundary   = !running || at_last;
      apply      = (pending || wr) && boundary;
      high_len   = half_ceil(32'(div_q));
      high_phase = 32'(cnt) < high_len;
   end

   // Configuration registers: a same-cycle write beats the stored shadow.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         div_q       <= DIV_W'(DEFAULT_DIV);
         mode_q      <= MODE_TOGGLE;
         shadow_div  <= DIV_W'(DEFAULT_DIV);
         shadow_mode <= MODE_TOGGLE;
         pending     <= 1'b0;
      end else begin
         if (wr) begin
            shadow_div  <= div_val;
            shadow_mode <= mode_val;
         end
         if (apply) begin
            div_q   <= wr ? div_val  : shadow_div;
            mode_q  <= wr ? mode_val : shadow_mode;
            pending <= 1'b0;
         end else if (wr) begin
            pending <= 1'b1;
         end
      end
   end

   // Counter and outputs; outputs reflect the count held before this edge.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (!running) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= (at_last || apply) ? '0 : cnt + {{(DIV_W-1){1'b0}}, 1'b1};
         tick    <= at_last;
         clk_out <= (mode_q == MODE_PULSE) ? at_last : high_phase;
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers sharing one clock.
// Decodes the single configuration write port into per-channel strobes.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int CHANNELS    = 4,
   parameter  int DIV_W       = 8,
   parameter  int DEFAULT_DIV = 2,
   localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic [CHANNELS-1:0] enable,
   input  logic                div_wr,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [DIV_W-1:0]    div_val,
   input  logic                mode_val,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending
);

   logic [CHANNELS-1:0] wr_hit;

   // Selects at or above CHANNELS match nothing, so such writes are dropped.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (div_wr && (32'(div_sel) == 32'(i))) wr_hit[i] = 1'b1;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      clk_div_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_in   (clk_in),
         .rst      (rst),
         .enable   (enable[g]),
         .wr       (wr_hit[g]),
         .div_val  (div_val),
         .mode_val (mode_val),
         .clk_out  (clk_out[g]),
         .tick     (tick[g]),
         .pending  (pending[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a per-channel period model built on
// modular arithmetic from each period's start cycle predicts every edge.
module tb_clk_div_bank;

   localparam int CH  = 5;
   localparam int DW  = 8;
   localparam int DEF = 2;
   localparam int SW  = 3;

   logic          clk_in = 1'b0;
   logic          rst;
   logic [CH-1:0] enable;
   logic          div_wr;
   logic [SW-1:0] div_sel;
   logic [DW-1:0] div_val;
   logic          mode_val;
   logic [CH-1:0] clk_out;
   logic [CH-1:0] tick;
   logic [CH-1:0] pending;

   clk_div_bank #(
      .CHANNELS    (CH),
      .DIV_W       (DW),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .enable   (enable),
      .div_wr   (div_wr),
      .div_sel  (div_sel),
      .div_val  (div_val),
      .mode_val (mode_val),
      .clk_out  (clk_out),
      .tick     (tick),
      .pending  (pending)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   // reference model state
   int m_d [CH];
   int m_mode [CH];
   int m_sd [CH];
   int m_smode [CH];
   int m_pend [CH];
   int m_base [CH];
   int cyc = 0;

   logic [3*CH-1:0] exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   done    = 1'b0;

   task automatic check(input string name, input int ch, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s ch%0d cycle-time %0t: got %b expected %b", name, ch, $time, act, exp);
      end
   endtask

   // driver: applies one cycle of inputs and pushes the predicted outputs
   task automatic step(input logic r, input logic [CH-1:0] en, input logic wr,
                       input logic [SW-1:0] sel, input logic [DW-1:0] val, input logic md);
      logic [CH-1:0] e_clk, e_tick, e_pend;
      rst = r; enable = en; div_wr = wr; div_sel = sel; div_val = val; mode_val = md;
      e_clk = '0; e_tick = '0; e_pend = '0;
      for (int c = 0; c < CH; c++) begin
         if (r) begin
            m_d[c] = DEF; m_mode[c] = 0; m_sd[c] = DEF; m_smode[c] = 0;
            m_pend[c] = 0; m_base[c] = cyc + 1;
         end else begin
            bit run, last, hit;
            int pos;
            run  = en[c] && (m_d[c] != 0);
            pos  = run ? (cyc - m_base[c]) % m_d[c] : 0;
            last = run && (pos == m_d[c] - 1);
            hit  = wr && (int'(sel) == c);
            e_tick[c] = last;
            e_clk[c]  = run && ((m_mode[c] == 1) ? last : (pos < (m_d[c] + 1) / 2));
            if ((m_pend[c] != 0 || hit) && (!run || last)) begin
               m_d[c]    = hit ? int'(val) : m_sd[c];
               m_mode[c] = hit ? int'(md)  : m_smode[c];
               if (hit) begin m_sd[c] = int'(val); m_smode[c] = int'(md); end
               m_pend[c] = 0;
               m_base[c] = cyc + 1;
            end else begin
               if (hit) begin m_sd[c] = int'(val); m_smode[c] = int'(md); m_pend[c] = 1; end
               if (!run) m_base[c] = cyc + 1;
            end
         end
         e_pend[c] = (m_pend[c] != 0);
      end
      cyc++;
      exp_q.push_back({e_pend, e_tick, e_clk});
      @(negedge clk_in);
   endtask

   task automatic idle(input int n, input logic [CH-1:0] en);
      for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic write(input logic [CH-1:0] en, input logic [SW-1:0] sel,
                        input logic [DW-1:0] val, input logic md);
      step(1'b0, en, 1'b1, sel, val, md);
   endtask

   // scoreboard monitor: one expected entry per clock edge
   initial begin
      logic [3*CH-1:0] e;
      forever begin
         @(posedge clk_in);
         #1;
         if (exp_q.size() == 0) begin
            if (!done) begin
               n_tests++; n_fail++;
               $display("FAIL queue_underflow: got empty queue expected an entry at %0t", $time);
            end
         end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < CH; c++) begin
               check("clk_out", c, clk_out[c], e[c]);
               check("tick",    c, tick[c],    e[CH + c]);
               check("pending", c, pending[c], e[2*CH + c]);
            end
         end
      end
   end

   // stimulus
   initial begin
      step(1'b1, 5'b00001, 1'b0, '0, '0, 1'b0);
      step(1'b1, 5'b00001, 1'b0, '0, '0, 1'b0);
      idle(8, 5'b00001);
      // ch0 to D=5 TOGGLE mid-period of the D=2 run
      write(5'b00001, 3'd0, 8'd5, 1'b0);
      idle(14, 5'b00001);
      // ch1: long period, then two writes before its boundary
      write(5'b00011, 3'd1, 8'd8, 1'b0);
      idle(3, 5'b00011);
      write(5'b00011, 3'd1, 8'd3, 1'b1);
      write(5'b00011, 3'd1, 8'd6, 1'b0);
      idle(20, 5'b00011);
      // ch2 D=1 TOGGLE, ch3 D=0 then a later write on the stopped channel
      write(5'b01111, 3'd2, 8'd1, 1'b0);
      write(5'b01111, 3'd3, 8'd0, 1'b0);
      idle(6, 5'b01111);
      write(5'b01111, 3'd3, 8'd3, 1'b1);
      idle(8, 5'b01111);
      // drop ch0 enable for 3 cycles
      idle(3, 5'b01110);
      idle(12, 5'b01111);
      // pending write then reset mid-period
      write(5'b01111, 3'd1, 8'd9, 1'b1);
      step(1'b1, 5'b01111, 1'b0, '0, '0, 1'b0);
      idle(6, 5'b01111);
      // out-of-range select, then D=255 on ch4
      write(5'b11111, 3'd7, 8'd3, 1'b1);
      write(5'b11111, 3'd5, 8'd4, 1'b1);
      idle(3, 5'b11111);
      write(5'b11111, 3'd4, 8'd255, 1'b0);
      idle(520, 5'b11111);
      write(5'b11111, 3'd4, 8'd255, 1'b1);
      idle(520, 5'b11111);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [CH-1:0] en;
         logic [DW-1:0] v;
         for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 7) != 0);
         v = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(200, 255))
                                          : DW'($urandom_range(0, 9));
         step(($urandom_range(0, 299) == 0), en, ($urandom_range(0, 5) == 0),
              SW'($urandom_range(0, 7)), v, 1'($urandom_range(0, 1)));
      end
      done = 1'b1;
      repeat (2) @(posedge clk_in);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock divider, successor to the fixed divide-by-2 `clk_div`. Each channel divides `clk_in` by a runtime-programmable integer. It produces either a near-50% duty divided clock or a single-cycle tick, plus an end-of-period tick in both modes. Sits beside `clk_div` as the source of slow clocks and clock enables for downstream logic. Divisor and mode changes are glitch-free: they apply only at a period boundary.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent divider channels (≥1).
- `DIV_W`, default 8: divisor width in bits.
- `DEFAULT_DIV`, default 2: divisor loaded into every channel at reset.

Ports:
- `clk_in`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `enable`, input, `CHANNELS`: per-channel run enable.
- `div_wr`, input, 1: write strobe for one channel's configuration.
- `div_sel`, input, `max(1,$clog2(CHANNELS))`: channel addressed by the write.
- `div_val`, input, `DIV_W`: new divisor D.
- `mode_val`, input, 1: new mode; 0 = TOGGLE, 1 = PULSE.
- `clk_out`, output, `CHANNELS`: divided clock (TOGGLE) or tick copy (PULSE).
- `tick`, output, `CHANNELS`: one-cycle pulse on the last cycle of each period.
- `pending`, output, `CHANNELS`: a written configuration is waiting for a boundary.

## Operation
- Per-channel state:
  - `cnt` (`DIV_W` bits)
  - active divisor D and mode
  - shadow divisor and shadow mode
  - `pending` flag
- Reset:
  - `cnt`=0, D=`DEFAULT_DIV`, mode=TOGGLE, `pending`=0.
  - Outputs `clk_out`=0, `tick`=0, `pending`=0.
- Counting (enable=1, D≥1):
  - `cnt` <= (`cnt`==D-1) ? 0 : `cnt`+1.
- Outputs are registered from the current `cnt`:
  - `tick` <= (`cnt`==D-1).
  - TOGGLE: `clk_out` <= (`cnt` < H), where H = ceil(D/2) = (D+1)>>1. High for H cycles, low for D-H cycles.
  - PULSE: `clk_out` <= (`cnt`==D-1), identical to `tick`.
- D=1: `tick` constant 1 while enabled; TOGGLE `clk_out` constant 1.
- D=0: channel stopped, same as enable=0.
- enable=0:
  - `cnt` <= 0, `clk_out` <= 0, `tick` <= 0.
  - Re-enabling restarts the phase exactly as after reset.
- Configuration write (`div_wr`=1, `div_sel`<`CHANNELS`):
  - Shadow <= {`div_val`, `mode_val`}; `pending` <= 1.
  - A later write before the boundary overwrites the shadow.
  - `div_sel`≥`CHANNELS`: write ignored.
- Apply rule, evaluated every cycle:
  - If `pending`, or a write hits this channel, and the channel is at a boundary, then active <= shadow (or the same-cycle write data, which takes priority), `pending` <= 0, `cnt` <= 0.
  - A boundary is `cnt`==D-1 with enable=1, or the channel is stopped (enable=0 or D=0).
- Arithmetic:
  - `cnt` compares are unsigned at `DIV_W` bits.
  - D-1 is computed only when D≥1.
  - `cnt`+1 never wraps because `cnt`<D≤2^`DIV_W`-1.
- Reset overrides everything mid-operation: `pending` cleared, shadow discarded, D restored to `DEFAULT_DIV`.

## Timing
- Output latency: 1 cycle from `cnt`. The first `clk_out` rise is at the first edge after `rst` falls (TOGGLE, D≥2).
- Example, TOGGLE D=4 after reset release, edges 1..8:
  - `clk_out` = 1,1,0,0,1,1,0,0
  - `tick` = 0,0,0,1,0,0,0,1
- `pending` rises one edge after the write.
- New D is visible in outputs starting with the period that follows the boundary edge.
- Write landing on a boundary cycle: applied at that same edge, and `pending` never asserts.
- A stopped channel applies a write at the next edge.
- Channels are fully independent. A write to one channel never perturbs another channel's phase.

## Structure
- Package `clk_div_pkg`:
  - Mode constants `MODE_TOGGLE`=0, `MODE_PULSE`=1.
  - Function `half_ceil(D)` returning (D+1)>>1.
- Sub-module `clk_div_chan`: one channel, holding the counter, shadow/active registers and output registers. It receives a decoded per-channel write strobe.
- `clk_div_bank`: decodes `div_sel`/`div_wr` and generate-instantiates `CHANNELS` copies of `clk_div_chan`.

## Test plan
- Reset then enable=4'b0001, default D=2 → ch0 `clk_out` toggles 1,0,1,0; `tick` on edges 2,4,6; ch1–3 stay 0.
- Write ch0 D=5 TOGGLE mid-period at `cnt`=0 of a D=2 run → `pending`=1 for one cycle, then the new period: `clk_out` high 3 cycles, low 2; `tick` every 5th edge.
- Write ch1 D=3 PULSE, then D=6 TOGGLE before the boundary → only D=6 is applied. Write coinciding with `cnt`==D-1 → applied that edge, `pending` stays 0.
- D=1 TOGGLE → `tick`=1 and `clk_out`=1 every cycle. D=0 → outputs 0, `cnt` held 0; a later write applies on the next edge.
- Drop enable mid-period for 3 cycles, then raise it → outputs 0 while low, phase restarts identically to post-reset; `rst` asserted mid-period with a pending write → `pending`=0, D=2 restored.
- Write with `div_sel`=7 when `CHANNELS`=4 → no channel changes; D=255 (`DIV_W`=8) → `tick` period exactly 255, H=128.
